// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order memory requests under a
// credit limit, buffers returned instructions and handles stall, redirect and flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_valid
);

  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [31:0]     target_pc;
  logic [CW:0]     credit_used;
  logic            pop, push, accept, drop_rsp;

  assign target_pc   = redirect_pc & ~32'h0000_0003;
  assign if_valid    = (count_q != '0);
  assign pop         = if_valid & ~stall & ~redirect;
  assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q} - {{CW{1'b0}}, pop};
  assign imem_req    = ~rst & ~redirect & (credit_used < DEPTH_W);
  assign imem_addr   = fetch_pc_q;
  assign accept      = imem_req & imem_ready;
  assign drop_rsp    = imem_rvalid & (drop_q != '0);
  assign push        = imem_rvalid & ~drop_rsp & ~redirect;

  assign if_pc          = if_valid ? fifo_q[rd_ptr_q].pc    : '0;
  assign if_instruction = if_valid ? fifo_q[rd_ptr_q].instr : NOP;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvalid);
    if (redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // Responses already marked for dropping are part of outstanding, so every
      // still-expected response becomes stale, including none arriving now.
      drop_d     = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (accept)   fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
      if (drop_rsp) drop_d   = drop_q - CW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // NOTE: the buffer storage has no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: resp_pc_q, instr: imem_rdata};
  end

endmodule
